// File: rtl/seg_scan_display.sv
// seg_scan_display: scans a 32-bit status word as 8 hex digits on a multiplexed 7-segment display
module seg_scan_display #(
  parameter int ADDR_BITS = 12,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           display_op,
  input  logic [ADDR_BITS-3:0] ram_display_addr,
  input  logic                 go,
  input  logic [31:0]          led_data,
  input  logic [31:0]          cycle_cnt,
  input  logic [31:0]          jump_cnt,
  input  logic [31:0]          branch_cnt,
  input  logic [31:0]          pc,
  input  logic [31:0]          ram_data,
  output logic [ADDR_BITS-3:0] ram_rd_addr,
  output logic [7:0]           an,
  output logic [7:0]           seg
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] scan_cnt;
  logic [2:0]    digit, op_q;
  logic [31:0]   snapshot, mux;
  logic [3:0]    nibble;
  logic [6:0]    hex;
  logic          scan_tick, blank;
  assign scan_tick = scan_cnt == CW'(SCAN_DIV - 1);
  assign nibble    = snapshot[{digit, 2'b00} +: 4];
  assign blank     = BLANK != 0 && digit != 3'd0 && (snapshot >> {digit, 2'b00}) == 32'h0;
  always_comb begin
    mux = 32'h0;
    case (display_op)
      3'd0: mux = led_data;
      3'd1: mux = cycle_cnt;
      3'd2: mux = jump_cnt;
      3'd3: mux = branch_cnt;
      3'd4: mux = ram_data;
      3'd5: mux = pc;
      3'd6: mux = 32'(ram_display_addr);
      default: mux = 32'h0;
    endcase
  end
  always_comb begin
    hex = 7'h7F;
    case (nibble)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      default: hex = 7'h0E;
    endcase
  end
  // snapshot only moves at frame boundaries or on a source switch, so a frame never mixes values
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt    <= '0;
      digit       <= 3'd0;
      snapshot    <= 32'h0;
      op_q        <= display_op;
      ram_rd_addr <= '0;
      an          <= 8'hFF;
      seg         <= 8'hFF;
    end else begin
      ram_rd_addr <= ram_display_addr;
      scan_cnt    <= scan_tick ? '0 : scan_cnt + 1'b1;
      digit       <= scan_tick ? digit + 3'd1 : digit;
      op_q        <= display_op;
      if ((scan_tick && digit == 3'd7) || display_op != op_q) snapshot <= mux;
      an          <= ~(8'b1 << digit);
      seg         <= {~(digit == 3'd0 && !go), blank ? 7'h7F : hex};
    end
  end
endmodule
